// File: rtl/lsu_axi_mem_controller_pkg.sv
// Shared types and defaults for the LSU-to-data-memory AXI-lite controller.
// The controller FSM state encoding is shared with anything that needs to observe it.
package lsu_axi_mem_controller_pkg;

  localparam int DEFAULT_THREADS_PER_WARP = 16;
  localparam int DEFAULT_ADDR_WIDTH       = 32;
  localparam int DEFAULT_DATA_WIDTH       = 32;

  typedef logic [DEFAULT_ADDR_WIDTH-1:0] data_memory_address_t;
  typedef logic [DEFAULT_DATA_WIDTH-1:0] data_t;

  typedef enum logic [2:0] {
    IDLE,
    RD_ADDR,
    RD_DATA,
    WR_REQ,
    WR_RESP,
    RD_DONE,
    WR_DONE
  } lsu_state_e;

endpackage

// File: rtl/lsu_axi_mem_controller_rr_arbiter.sv
// Combinational round-robin arbiter: the first requester at or after the pointer
// (wrapping) wins.
module lsu_axi_mem_controller_rr_arbiter #(
  parameter int N     = 17,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     request,
  input  logic [IDX_W-1:0] pointer,
  output logic             grant_valid,
  output logic [IDX_W-1:0] grant_index,
  output logic [N-1:0]     grant_onehot
);

  // NOTE: every signal driven here gets a default before any conditional
  // assignment, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    grant_valid  = 1'b0;
    grant_index  = '0;
    grant_onehot = '0;
    // Walk from the farthest offset back to the pointer so the nearest requester wins.
    for (int off = N - 1; off >= 0; off--) begin
      if (request[(int'(pointer) + off) % N]) begin
        grant_valid = 1'b1;
        grant_index = IDX_W'((int'(pointer) + off) % N);
      end
    end
    if (grant_valid) grant_onehot[grant_index] = 1'b1;
  end

endmodule

// File: rtl/lsu_axi_mem_controller.sv
// Arbitrates THREADS_PER_WARP vector LSUs plus one scalar LSU onto a single
// AXI-lite data-memory master, one transaction at a time, round-robin.
module lsu_axi_mem_controller
  import lsu_axi_mem_controller_pkg::*;
#(
  parameter int THREADS_PER_WARP = DEFAULT_THREADS_PER_WARP,
  parameter int ADDR_WIDTH       = DEFAULT_ADDR_WIDTH,
  parameter int DATA_WIDTH       = DEFAULT_DATA_WIDTH
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic [THREADS_PER_WARP:0]                consumer_read_valid,
  input  logic [THREADS_PER_WARP:0][ADDR_WIDTH-1:0] consumer_read_address,
  output logic [THREADS_PER_WARP:0]                consumer_read_ready,
  output logic [THREADS_PER_WARP:0][DATA_WIDTH-1:0] consumer_read_data,
  input  logic [THREADS_PER_WARP:0]                consumer_write_valid,
  input  logic [THREADS_PER_WARP:0][ADDR_WIDTH-1:0] consumer_write_address,
  input  logic [THREADS_PER_WARP:0][DATA_WIDTH-1:0] consumer_write_data,
  output logic [THREADS_PER_WARP:0]                consumer_write_ready,
  output logic [ADDR_WIDTH-1:0]                    m_axi_awaddr,
  output logic                                     m_axi_awvalid,
  input  logic                                     m_axi_awready,
  output logic [DATA_WIDTH-1:0]                    m_axi_wdata,
  output logic                                     m_axi_wvalid,
  input  logic                                     m_axi_wready,
  input  logic                                     m_axi_bvalid,
  output logic [ADDR_WIDTH-1:0]                    m_axi_araddr,
  output logic                                     m_axi_arvalid,
  input  logic                                     m_axi_arready,
  input  logic [DATA_WIDTH-1:0]                    m_axi_rdata,
  input  logic                                     m_axi_rvalid
);

  localparam int NUM_CONSUMERS = THREADS_PER_WARP + 1;
  localparam int IDX_W         = $clog2(NUM_CONSUMERS);

  lsu_state_e       state, state_n;
  logic [IDX_W-1:0] ptr, ptr_n;
  logic [IDX_W-1:0] idx, idx_n;

  logic [ADDR_WIDTH-1:0]                    araddr_n, awaddr_n;
  logic [DATA_WIDTH-1:0]                    wdata_n;
  logic                                     arvalid_n, awvalid_n, wvalid_n;
  logic [NUM_CONSUMERS-1:0]                 read_ready_n, write_ready_n;
  logic [NUM_CONSUMERS-1:0][DATA_WIDTH-1:0] read_data_n;

  logic                     grant_valid;
  logic [IDX_W-1:0]         grant_index;
  logic [NUM_CONSUMERS-1:0] grant_onehot;

  lsu_axi_mem_controller_rr_arbiter #(
    .N     (NUM_CONSUMERS),
    .IDX_W (IDX_W)
  ) u_arbiter (
    .request      (consumer_read_valid | consumer_write_valid),
    .pointer      (ptr),
    .grant_valid  (grant_valid),
    .grant_index  (grant_index),
    .grant_onehot (grant_onehot)
  );

  always_comb begin
    state_n       = state;
    ptr_n         = ptr;
    idx_n         = idx;
    araddr_n      = m_axi_araddr;
    arvalid_n     = m_axi_arvalid;
    awaddr_n      = m_axi_awaddr;
    awvalid_n     = m_axi_awvalid;
    wdata_n       = m_axi_wdata;
    wvalid_n      = m_axi_wvalid;
    read_ready_n  = consumer_read_ready;
    write_ready_n = consumer_write_ready;
    read_data_n   = consumer_read_data;

    case (state)
      IDLE: begin
        araddr_n = '0;
        awaddr_n = '0;
        wdata_n  = '0;
        if (grant_valid) begin
          idx_n = grant_index;
          ptr_n = (grant_index == IDX_W'(NUM_CONSUMERS - 1)) ? '0 : grant_index + 1'b1;
          // A consumer asking for both is served its read now; the write waits its turn.
          if (consumer_read_valid[grant_index]) begin
            araddr_n  = consumer_read_address[grant_index];
            arvalid_n = 1'b1;
            state_n   = RD_ADDR;
          end else begin
            awaddr_n  = consumer_write_address[grant_index];
            wdata_n   = consumer_write_data[grant_index];
            awvalid_n = 1'b1;
            wvalid_n  = 1'b1;
            state_n   = WR_REQ;
          end
        end
      end

      RD_ADDR: begin
        if (m_axi_arready) begin
          arvalid_n = 1'b0;
          if (m_axi_rvalid) begin
            read_data_n[idx] = m_axi_rdata;
            state_n          = RD_DONE;
          end else begin
            state_n = RD_DATA;
          end
        end
      end

      RD_DATA: begin
        if (m_axi_rvalid) begin
          read_data_n[idx] = m_axi_rdata;
          state_n          = RD_DONE;
        end
      end

      WR_REQ: begin
        if (m_axi_awready && m_axi_wready) begin
          awvalid_n = 1'b0;
          wvalid_n  = 1'b0;
          state_n   = m_axi_bvalid ? WR_DONE : WR_RESP;
        end
      end

      WR_RESP: begin
        if (m_axi_bvalid) state_n = WR_DONE;
      end

      // Ready rises on the first DONE cycle and is only checked against the
      // consumer's valid once it is already high, guaranteeing one full cycle.
      RD_DONE: begin
        if (!consumer_read_ready[idx]) begin
          read_ready_n[idx] = 1'b1;
        end else if (!consumer_read_valid[idx]) begin
          read_ready_n[idx] = 1'b0;
          state_n           = IDLE;
        end
      end

      WR_DONE: begin
        if (!consumer_write_ready[idx]) begin
          write_ready_n[idx] = 1'b1;
        end else if (!consumer_write_valid[idx]) begin
          write_ready_n[idx] = 1'b0;
          state_n            = IDLE;
        end
      end

      default: state_n = IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the values from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state                <= IDLE;
      ptr                  <= '0;
      idx                  <= '0;
      m_axi_araddr         <= '0;
      m_axi_arvalid        <= 1'b0;
      m_axi_awaddr         <= '0;
      m_axi_awvalid        <= 1'b0;
      m_axi_wdata          <= '0;
      m_axi_wvalid         <= 1'b0;
      consumer_read_ready  <= '0;
      consumer_write_ready <= '0;
      // NOTE: the read-data bank is a handful of flops, not a RAM macro, so
      // clearing it on reset is cheap and keeps every output defined.
      consumer_read_data   <= '0;
    end else begin
      state                <= state_n;
      ptr                  <= ptr_n;
      idx                  <= idx_n;
      m_axi_araddr         <= araddr_n;
      m_axi_arvalid        <= arvalid_n;
      m_axi_awaddr         <= awaddr_n;
      m_axi_awvalid        <= awvalid_n;
      m_axi_wdata          <= wdata_n;
      m_axi_wvalid         <= wvalid_n;
      consumer_read_ready  <= read_ready_n;
      consumer_write_ready <= write_ready_n;
      consumer_read_data   <= read_data_n;
    end
  end

endmodule

// File: tb/tb_lsu_axi_mem_controller.sv
// Bench for lsu_axi_mem_controller: an AXI-lite memory responder with tunable
// latencies plus a round-robin reference model that predicts service order and data.
module tb_lsu_axi_mem_controller;
  import lsu_axi_mem_controller_pkg::*;

  localparam int TPW = 16;
  localparam int NC  = TPW + 1;

  typedef struct {
    int          idx;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
  } axi_rec_t;

  logic clk = 1'b0;
  logic reset;

  logic [NC-1:0]         consumer_read_valid;
  logic [NC-1:0][31:0]   consumer_read_address;
  logic [NC-1:0]         consumer_read_ready;
  logic [NC-1:0][31:0]   consumer_read_data;
  logic [NC-1:0]         consumer_write_valid;
  logic [NC-1:0][31:0]   consumer_write_address;
  logic [NC-1:0][31:0]   consumer_write_data;
  logic [NC-1:0]         consumer_write_ready;
  logic [31:0]           m_axi_awaddr, m_axi_wdata, m_axi_araddr;
  logic                  m_axi_awvalid, m_axi_wvalid, m_axi_arvalid;
  logic                  m_axi_awready = 1'b0;
  logic                  m_axi_wready  = 1'b0;
  logic                  m_axi_bvalid  = 1'b0;
  logic                  m_axi_arready = 1'b0;
  logic                  m_axi_rvalid  = 1'b0;
  logic [31:0]           m_axi_rdata   = '0;

  int errors = 0;
  int checks = 0;

  // Memory seen by the responder, and the model's independent copy.
  logic [31:0] mem     [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];
  int          ref_ptr = 0;
  axi_rec_t    ax_log[$];

  int ar_wait = 0, r_lag = 0, aw_wait = 0, b_lag = 0;
  int ar_cnt = 0, aw_cnt = 0, rd_cnt = 0, wr_cnt = 0;
  bit rd_pend = 0, wr_pend = 0, b_seen = 0;
  logic [31:0] rd_val;
  int rule_violations = 0;

  lsu_axi_mem_controller #(
    .THREADS_PER_WARP (TPW),
    .ADDR_WIDTH       (32),
    .DATA_WIDTH       (32)
  ) dut (
    .clk                    (clk),
    .reset                  (reset),
    .consumer_read_valid    (consumer_read_valid),
    .consumer_read_address  (consumer_read_address),
    .consumer_read_ready    (consumer_read_ready),
    .consumer_read_data     (consumer_read_data),
    .consumer_write_valid   (consumer_write_valid),
    .consumer_write_address (consumer_write_address),
    .consumer_write_data    (consumer_write_data),
    .consumer_write_ready   (consumer_write_ready),
    .m_axi_awaddr           (m_axi_awaddr),
    .m_axi_awvalid          (m_axi_awvalid),
    .m_axi_awready          (m_axi_awready),
    .m_axi_wdata            (m_axi_wdata),
    .m_axi_wvalid           (m_axi_wvalid),
    .m_axi_wready           (m_axi_wready),
    .m_axi_bvalid           (m_axi_bvalid),
    .m_axi_araddr           (m_axi_araddr),
    .m_axi_arvalid          (m_axi_arvalid),
    .m_axi_arready          (m_axi_arready),
    .m_axi_rdata            (m_axi_rdata),
    .m_axi_rvalid           (m_axi_rvalid)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_default(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [31:0] slave_read(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : mem_default(a);
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : mem_default(a);
  endfunction

  // AXI-lite memory responder, driven on the falling edge.
  always @(negedge clk) begin
    m_axi_arready = 1'b0;
    m_axi_rvalid  = 1'b0;
    m_axi_rdata   = $urandom;
    m_axi_awready = 1'b0;
    m_axi_wready  = 1'b0;
    m_axi_bvalid  = 1'b0;
    if ((m_axi_arvalid && m_axi_awvalid) || (m_axi_awvalid !== m_axi_wvalid)) rule_violations++;
    if (!reset) begin
      ar_cnt = 0; aw_cnt = 0; rd_pend = 0; wr_pend = 0;
    end else begin
      if (rd_pend) begin
        if (rd_cnt == 0) begin
          m_axi_rvalid = 1'b1; m_axi_rdata = rd_val; rd_pend = 0;
        end else rd_cnt--;
      end else if (m_axi_arvalid) begin
        if (ar_cnt >= ar_wait) begin
          m_axi_arready = 1'b1; ar_cnt = 0;
          rd_val = slave_read(m_axi_araddr);
          ax_log.push_back('{wr: 1'b0, addr: m_axi_araddr, data: rd_val});
          if (r_lag == 0) begin
            m_axi_rvalid = 1'b1; m_axi_rdata = rd_val;
          end else begin
            rd_pend = 1; rd_cnt = r_lag - 1;
          end
        end else ar_cnt++;
      end
      if (wr_pend) begin
        if (wr_cnt == 0) begin
          m_axi_bvalid = 1'b1; b_seen = 1; wr_pend = 0;
        end else wr_cnt--;
      end else if (m_axi_awvalid && m_axi_wvalid) begin
        if (aw_cnt >= aw_wait) begin
          m_axi_awready = 1'b1; m_axi_wready = 1'b1; aw_cnt = 0;
          mem[m_axi_awaddr] = m_axi_wdata;
          ax_log.push_back('{wr: 1'b1, addr: m_axi_awaddr, data: m_axi_wdata});
          if (b_lag == 0) begin
            m_axi_bvalid = 1'b1; b_seen = 1;
          end else begin
            wr_pend = 1; wr_cnt = b_lag - 1;
          end
        end else aw_cnt++;
      end
    end
  end

  task automatic clear_consumers();
    consumer_read_valid    = '0;
    consumer_write_valid   = '0;
    consumer_read_address  = '0;
    consumer_write_address = '0;
    consumer_write_data    = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    clear_consumers();
    @(negedge clk);
    @(negedge clk);
    reset   = 1'b1;
    ref_ptr = 0;
  endtask

  // Issue a set of simultaneous requests (addresses already placed on the
  // consumer buses), then act as every LSU until all are served, checking order,
  // data and the AXI traffic against the round-robin model.
  task automatic run_batch(input logic [NC-1:0] rd_en, input logic [NC-1:0] wr_en,
                           input int budget, input string name);
    exp_t          exp_q[$];
    logic [NC-1:0] rp, wp;
    rp = rd_en;
    wp = wr_en;
    while ((rp | wp) != '0) begin
      exp_t e;
      int   w;
      w = 0;
      for (int off = 0; off < NC; off++) begin
        int c = (ref_ptr + off) % NC;
        if (rp[c] || wp[c]) begin
          w = c;
          break;
        end
      end
      e.idx = w;
      if (rp[w]) begin
        e.wr = 0; e.addr = consumer_read_address[w]; e.data = ref_read(e.addr);
        rp[w] = 1'b0;
      end else begin
        e.wr = 1; e.addr = consumer_write_address[w]; e.data = consumer_write_data[w];
        ref_mem[e.addr] = e.data;
        wp[w] = 1'b0;
      end
      ref_ptr = (w + 1) % NC;
      exp_q.push_back(e);
    end

    ax_log.delete();
    @(negedge clk);
    consumer_read_valid  = rd_en;
    consumer_write_valid = wr_en;
    for (int cyc = 0; cyc < budget && exp_q.size() > 0; cyc++) begin
      @(negedge clk);
      for (int i = 0; i < NC; i++) begin
        for (int k = 0; k < 2; k++) begin
          bit hit;
          hit = (k == 0) ? (consumer_read_ready[i] && consumer_read_valid[i])
                         : (consumer_write_ready[i] && consumer_write_valid[i]);
          if (hit) begin
            exp_t e;
            checks++;
            if (exp_q.size() == 0) begin
              errors++;
              $display("FAIL %s_extra: unexpected ready from lsu %0d wr=%0d", name, i, k);
            end else begin
              e = exp_q.pop_front();
              if (e.idx != i || int'(e.wr) != k) begin
                errors++;
                $display("FAIL %s_order: served lsu %0d wr=%0d, expected lsu %0d wr=%0d",
                         name, i, k, e.idx, e.wr);
              end
              if (k == 0) begin
                checks++;
                if (consumer_read_data[i] !== e.data) begin
                  errors++;
                  $display("FAIL %s_rdata: lsu %0d got %h expected %h", name, i,
                           consumer_read_data[i], e.data);
                end
              end
              checks++;
              if (ax_log.size() == 0) begin
                errors++;
                $display("FAIL %s_axi: no AXI transfer logged, expected addr %h", name, e.addr);
              end else begin
                axi_rec_t r;
                r = ax_log.pop_front();
                if (r.wr != e.wr || r.addr !== e.addr || (e.wr && r.data !== e.data)) begin
                  errors++;
                  $display("FAIL %s_axi: got wr=%0d addr=%h data=%h expected wr=%0d addr=%h data=%h",
                           name, r.wr, r.addr, r.data, e.wr, e.addr, e.data);
                end
              end
            end
            if (k == 0) consumer_read_valid[i] = 1'b0;
            else        consumer_write_valid[i] = 1'b0;
          end
        end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_timeout: %0d transactions outstanding, expected 0", name, exp_q.size());
    end
    clear_consumers();
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({m_axi_arvalid, m_axi_awvalid, m_axi_wvalid} !== 3'b000) begin
      errors++; $display("FAIL reset_valids: got %b expected 000", {m_axi_arvalid, m_axi_awvalid, m_axi_wvalid});
    end
    checks++;
    if ({m_axi_araddr, m_axi_awaddr, m_axi_wdata} !== '0) begin
      errors++; $display("FAIL reset_addr_data: got %h %h %h expected 0", m_axi_araddr, m_axi_awaddr, m_axi_wdata);
    end
    checks++;
    if ({consumer_read_ready, consumer_write_ready} !== '0) begin
      errors++; $display("FAIL reset_readies: got %h %h expected 0", consumer_read_ready, consumer_write_ready);
    end
    checks++;
    if (consumer_read_data !== '0) begin
      errors++; $display("FAIL reset_read_data: got nonzero expected 0");
    end
    reset   = 1'b1;
    ref_ptr = 0;
  endtask

  task automatic test_single_read();
    logic [NC-1:0] exp_rdy;
    exp_rdy = '0;
    exp_rdy[3] = 1'b1;
    do_reset();
    ar_wait = 0; r_lag = 0;
    mem[32'h40] = 32'hDEAD_BEEF;
    ref_mem[32'h40] = 32'hDEAD_BEEF;
    @(negedge clk);
    consumer_read_address[3] = 32'h40;
    consumer_read_valid[3]   = 1'b1;
    @(negedge clk);
    checks++;
    if (m_axi_arvalid !== 1'b1 || m_axi_araddr !== 32'h40) begin
      errors++; $display("FAIL rd_grant: arvalid=%b araddr=%h expected 1 and 00000040", m_axi_arvalid, m_axi_araddr);
    end
    @(negedge clk);
    checks++;
    if (m_axi_arvalid !== 1'b0 || consumer_read_ready !== '0 || consumer_read_data[3] !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL rd_capture: arvalid=%b ready=%h data=%h expected 0, 0, deadbeef",
                         m_axi_arvalid, consumer_read_ready, consumer_read_data[3]);
    end
    @(negedge clk);
    checks++;
    if (consumer_read_ready !== exp_rdy) begin
      errors++; $display("FAIL rd_ready: got %h expected %h", consumer_read_ready, exp_rdy);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (consumer_read_ready !== exp_rdy) begin
      errors++; $display("FAIL rd_ready_hold: got %h expected %h", consumer_read_ready, exp_rdy);
    end
    consumer_read_valid[3] = 1'b0;
    @(negedge clk);
    checks++;
    if (consumer_read_ready !== '0 || consumer_read_data[3] !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL rd_release: ready=%h data=%h expected 0 and deadbeef",
                         consumer_read_ready, consumer_read_data[3]);
    end
    ref_ptr = 4;
    clear_consumers();
  endtask

  task automatic test_single_write();
    bit early, done;
    early = 0; done = 0;
    do_reset();
    aw_wait = 0; b_lag = 3; b_seen = 0;
    @(negedge clk);
    consumer_write_address[16] = 32'h80;
    consumer_write_data[16]    = 32'h1234;
    consumer_write_valid[16]   = 1'b1;
    @(negedge clk);
    checks++;
    if (m_axi_awvalid !== 1'b1 || m_axi_wvalid !== 1'b1 || m_axi_awaddr !== 32'h80 || m_axi_wdata !== 32'h1234) begin
      errors++; $display("FAIL wr_request: awvalid=%b wvalid=%b awaddr=%h wdata=%h expected 1 1 00000080 00001234",
                         m_axi_awvalid, m_axi_wvalid, m_axi_awaddr, m_axi_wdata);
    end
    for (int cyc = 0; cyc < 20 && !done; cyc++) begin
      @(negedge clk);
      if (consumer_write_ready != '0 && !b_seen) early = 1;
      if (consumer_write_ready[16]) done = 1;
    end
    checks++;
    if (!done || early) begin
      errors++; $display("FAIL wr_ready_after_b: done=%0d early=%0d expected 1 0", done, early);
    end
    checks++;
    if (slave_read(32'h80) !== 32'h1234) begin
      errors++; $display("FAIL wr_memory: got %h expected 00001234", slave_read(32'h80));
    end
    ref_mem[32'h80] = 32'h1234;
    consumer_write_valid[16] = 1'b0;
    @(negedge clk);
    checks++;
    if (consumer_write_ready !== '0) begin
      errors++; $display("FAIL wr_release: got %h expected 0", consumer_write_ready);
    end
    ref_ptr = 0;
    b_lag = 0;
    clear_consumers();
  endtask

  task automatic test_round_robin();
    logic [NC-1:0] rd;
    do_reset();
    ar_wait = 1; r_lag = 1;
    for (int i = 0; i < NC; i++) consumer_read_address[i] = 32'h2000 + 32'(i * 4);
    rd = '0; rd[0] = 1; rd[5] = 1; rd[16] = 1;
    run_batch(rd, '0, 200, "rr_first");
    for (int i = 0; i < NC; i++) consumer_read_address[i] = 32'h3000 + 32'(i * 4);
    rd = '0; rd[0] = 1; rd[5] = 1;
    run_batch(rd, '0, 200, "rr_second");
  endtask

  task automatic test_read_write_same();
    logic [NC-1:0] en;
    do_reset();
    ar_wait = 0; r_lag = 2; aw_wait = 1; b_lag = 1;
    rule_violations = 0;
    en = '0; en[2] = 1'b1;
    consumer_read_address[2]  = 32'h100;
    consumer_write_address[2] = 32'h100;
    consumer_write_data[2]    = $urandom;
    run_batch(en, en, 200, "rw_same");
    consumer_read_address[2] = 32'h100;
    run_batch(en, '0, 200, "rw_readback");
    checks++;
    if (rule_violations != 0) begin
      errors++; $display("FAIL rw_axi_exclusive: %0d violations expected 0", rule_violations);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] addr;
    bit stable, done;
    addr = $urandom & 32'hFFFF_FFFC;
    stable = 1; done = 0;
    ar_wait = 10; r_lag = 1;
    ax_log.delete();
    @(negedge clk);
    consumer_read_address[7] = addr;
    consumer_read_valid[7]   = 1'b1;
    for (int cyc = 0; cyc < 10; cyc++) begin
      @(negedge clk);
      if (m_axi_arvalid !== 1'b1 || m_axi_araddr !== addr || consumer_read_ready !== '0) stable = 0;
      if (cyc == 3) consumer_read_address[7] = ~addr;
    end
    checks++;
    if (!stable) begin
      errors++; $display("FAIL bp_stable: arvalid=%b araddr=%h expected 1 and %h while stalled",
                         m_axi_arvalid, m_axi_araddr, addr);
    end
    for (int cyc = 0; cyc < 20 && !done; cyc++) begin
      @(negedge clk);
      if (consumer_read_ready[7]) done = 1;
    end
    checks++;
    if (!done || consumer_read_data[7] !== ref_read(addr)) begin
      errors++; $display("FAIL bp_data: done=%0d data=%h expected 1 and %h", done, consumer_read_data[7], ref_read(addr));
    end
    checks++;
    if (ax_log.size() != 1 || ax_log[0].addr !== addr) begin
      errors++; $display("FAIL bp_addr_latched: %0d transfers, first addr %h expected 1 at %h",
                         ax_log.size(), (ax_log.size() > 0) ? ax_log[0].addr : 32'h0, addr);
    end
    ref_ptr = 8;
    clear_consumers();
    @(negedge clk);
    @(negedge clk);
    ar_wait = 0;
  endtask

  task automatic test_async_reset();
    bit quiet;
    logic [NC-1:0] en;
    quiet = 1;
    ar_wait = 0; r_lag = 30;
    @(negedge clk);
    consumer_read_address[9] = 32'h200;
    consumer_read_valid[9]   = 1'b1;
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({m_axi_arvalid, m_axi_awvalid, m_axi_wvalid, m_axi_araddr, m_axi_awaddr, m_axi_wdata} !== '0 ||
        {consumer_read_ready, consumer_write_ready} !== '0 || consumer_read_data !== '0) begin
      errors++; $display("FAIL async_reset_outputs: araddr=%h rdy=%h data0=%h expected all 0",
                         m_axi_araddr, consumer_read_ready, consumer_read_data[0]);
    end
    clear_consumers();
    @(negedge clk);
    @(negedge clk);
    reset   = 1'b1;
    ref_ptr = 0;
    repeat (4) begin
      @(negedge clk);
      if (consumer_read_ready !== '0 || m_axi_arvalid !== 1'b0) quiet = 0;
    end
    checks++;
    if (!quiet) begin
      errors++; $display("FAIL async_reset_abandon: ready=%h arvalid=%b expected 0 0", consumer_read_ready, m_axi_arvalid);
    end
    r_lag = 2;
    en = '0; en[9] = 1'b1;
    consumer_read_address[9] = 32'h200;
    run_batch(en, '0, 100, "post_reset");
  endtask

  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      logic [NC-1:0] rd, wr;
      rd = NC'($urandom & $urandom);
      wr = NC'($urandom & $urandom);
      for (int i = 0; i < NC; i++) begin
        consumer_read_address[i]  = 32'h1000 + {26'd0, 4'($urandom_range(0, 15)), 2'b00};
        consumer_write_address[i] = 32'h1000 + {26'd0, 4'($urandom_range(0, 15)), 2'b00};
        consumer_write_data[i]    = $urandom;
      end
      ar_wait = $urandom_range(0, 2); r_lag = $urandom_range(0, 3);
      aw_wait = $urandom_range(0, 2); b_lag = $urandom_range(0, 3);
      run_batch(rd, wr, 3000, "random");
    end
  endtask

  initial begin
    reset = 1'b0;
    clear_consumers();
    test_reset();
    test_single_read();
    test_single_write();
    test_round_robin();
    test_read_write_same();
    test_backpressure();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1);
  end

endmodule

// File: doc/lsu_axi_mem_controller.md
Name: lsu_axi_mem_controller

Overview:
- Arbitrates the per-core load/store units onto one AXI-lite-style master port to data memory.
- There are THREADS_PER_WARP vector LSUs plus one scalar LSU.
- Sits between compute_core's data-memory ports and the GPU top-level data-memory channel.
- Serves exactly one memory transaction at a time, granting consumers round-robin.

Parameters:
- THREADS_PER_WARP, 16, number of vector LSUs. Consumer count is NUM_CONSUMERS = THREADS_PER_WARP+1 (localparam). Index THREADS_PER_WARP is the scalar LSU.
- ADDR_WIDTH, 32, data-memory address width (data_memory_address_t).
- DATA_WIDTH, 32, data word width (data_t).

Ports:
- clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-low reset; 0 = reset asserted.
- consumer_read_valid  in  NUM_CONSUMERS  per-LSU read request.
- consumer_read_address  in  NUM_CONSUMERS x ADDR_WIDTH  read address per LSU.
- consumer_read_ready  out  NUM_CONSUMERS  read completed; consumer_read_data is valid.
- consumer_read_data  out  NUM_CONSUMERS x DATA_WIDTH  returned data per LSU.
- consumer_write_valid  in  NUM_CONSUMERS  per-LSU write request.
- consumer_write_address  in  NUM_CONSUMERS x ADDR_WIDTH  write address.
- consumer_write_data  in  NUM_CONSUMERS x DATA_WIDTH  write data.
- consumer_write_ready  out  NUM_CONSUMERS  write completed.
- m_axi_awaddr  out  ADDR_WIDTH; m_axi_awvalid  out  1; m_axi_awready  in  1.
- m_axi_wdata  out  DATA_WIDTH; m_axi_wvalid  out  1; m_axi_wready  in  1.
- m_axi_bvalid  in  1  write response.
- m_axi_araddr  out  ADDR_WIDTH; m_axi_arvalid  out  1; m_axi_arready  in  1.
- m_axi_rdata  in  DATA_WIDTH; m_axi_rvalid  in  1.

Behaviour:
- All outputs registered.
- Reset asynchronously clears:
  - all valids, readies, addresses and data, and every consumer_read_data entry, to 0;
  - state to IDLE;
  - round-robin pointer to 0.
- Reset mid-transaction abandons the transaction; no ready is issued for it.
- FSM states: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, RD_DONE, WR_DONE.
- IDLE arbitration:
  - Scan consumers starting at the pointer, wrapping modulo NUM_CONSUMERS.
  - The first index with read_valid or write_valid wins.
  - If the winner has both, read is served first; its write is served in a later arbitration.
  - Pointer becomes winner+1, wrapping to 0 after index NUM_CONSUMERS-1.
  - Grant latches the index, address and data, then goes to RD_ADDR (arvalid=1) or WR_REQ (awvalid=wvalid=1).
  - Zero requests: stay in IDLE with all outputs low.
- RD_ADDR:
  - Hold arvalid/araddr until arready is high; then drop arvalid.
  - If rvalid is also high that cycle, capture rdata and go to RD_DONE; otherwise go to RD_DATA.
- RD_DATA: wait for rvalid, capture rdata into consumer_read_data[idx], go to RD_DONE.
- WR_REQ:
  - awvalid and wvalid are asserted together and dropped together once awready && wready.
  - If bvalid is high that same cycle, go to WR_DONE; otherwise go to WR_RESP.
- WR_RESP: wait for bvalid, then go to WR_DONE.
- RD_DONE / WR_DONE:
  - Assert consumer_read_ready[idx] (or consumer_write_ready[idx]) and hold it until that consumer drops its valid.
  - Then clear ready and return to IDLE. Minimum one cycle of ready.
- Request stability:
  - Consumers hold their valid, address and data stable until ready.
  - Address and data are latched at grant; later changes do not affect the transaction in flight.
- consumer_read_data[i] retains its last value until overwritten.
- At most one of arvalid, awvalid is high in any cycle; no outstanding transactions overlap.
- Latency with memory ready every cycle: grant at edge 1, AXI handshake at edge 2, consumer ready at edge 3.

Decomposition:
- Shared package: data_t, data_memory_address_t, THREADS_PER_WARP default, FSM state enum.
- One natural sub-module: rr_arbiter.
  - Inputs: request vector (read_valid | write_valid) and pointer.
  - Outputs: one-hot/index grant.
  - Combinational.

Test Plan:
- Single read: LSU 3 reads 0x40, memory returns 0xDEADBEEF with arready=rvalid high at the same edge -> araddr=0x40, consumer_read_data[3]=0xDEADBEEF, consumer_read_ready[3] high until read_valid[3] drops.
- Single write: scalar LSU 16 writes 0x1234 to 0x80 with bvalid delayed 3 cycles -> awaddr=0x80 and wdata=0x1234 while awvalid=wvalid=1; write_ready[16] only after bvalid.
- Round-robin: LSUs 0, 5 and 16 all request reads at once -> service order 0, 5, 16; a new request from 0 after 16 is served before 5 re-requests.
- Read+write same LSU: LSU 2 asserts both -> read completes first, write served on a later grant; never both AXI valids high.
- Backpressure: arready held low 10 cycles -> arvalid and araddr stable, no ready to the consumer.
- Async reset mid-read: reset=0 during RD_DATA -> all outputs 0 immediately; after release, a fresh request completes normally.
